// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
//   div_state_t   : controller state encoding (IDLE, SUB, DONE), 2 bits
//   DIV_ZERO_QUOT : quotient reported for a zero divisor (all ones; slice to width)
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SUB  = 2'b01,
      DONE = 2'b10
   } div_state_t;

   localparam logic [63:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/seq_divider_ctrl.sv
// seq_divider_ctrl: start/done control FSM for the repeated-subtraction divider.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : operation request (honoured in IDLE and DONE only)
//   ge        : remainder >= divisor
//   dz        : incoming divisor is zero
//   load      : latch operands this cycle
//   sub_en    : perform one subtract/count step this cycle
//   set_dz    : divide-by-zero operation accepted this cycle
//   busy      : high in SUB
//   done      : high in DONE
module seq_divider_ctrl
   import div_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic ge,
   input  logic dz,
   output logic load,
   output logic sub_en,
   output logic set_dz,
   output logic busy,
   output logic done
);

   div_state_t state, state_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      sub_en     = 1'b0;
      set_dz     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start) begin
               load       = 1'b1;
               set_dz     = dz;
               // A zero divisor skips SUB entirely; the result is fixed.
               state_next = dz ? DONE : SUB;
            end
         end
         SUB: begin
            busy = 1'b1;
            if (ge) begin
               sub_en = 1'b1;
            end else begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned divider by repeated subtraction with start/done handshake.
// Optional feature macro: DIVZERO_FLAG_EN (adds the registered div_zero output).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request; operands latched when accepted
//   in1, in2   : dividend, divisor
//   quotient   : registered quotient (all ones for a zero divisor)
//   remainder  : registered remainder (in1 for a zero divisor)
//   busy       : division in progress
//   done       : result valid
//   div_zero   : last accepted operation had a zero divisor (DIVZERO_FLAG_EN only)
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
`ifdef DIVZERO_FLAG_EN
   output logic             done,
   output logic             div_zero
`else
   output logic             done
`endif
);

   logic [WIDTH-1:0] dvs;
   logic             load;
   logic             sub_en;
   logic             set_dz;
   logic             ge;
   logic             dz;

   assign ge = (remainder >= dvs);
   assign dz = (in2 == '0);

   seq_divider_ctrl u_ctrl (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .ge     (ge),
      .dz     (dz),
      .load   (load),
      .sub_en (sub_en),
      .set_dz (set_dz),
      .busy   (busy),
      .done   (done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         dvs       <= '0;
         remainder <= '0;
         quotient  <= '0;
      end else if (load) begin
         dvs       <= in2;
         remainder <= in1;
         quotient  <= dz ? DIV_ZERO_QUOT[WIDTH-1:0] : '0;
      end else if (sub_en) begin
         // sub_en only fires when remainder >= dvs, so no underflow or wrap.
         remainder <= remainder - dvs;
         quotient  <= quotient + WIDTH'(1);
      end
   end

`ifdef DIVZERO_FLAG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         div_zero <= 1'b0;
      end else if (load) begin
         div_zero <= set_dz;
      end
   end
`else
   logic unused_set_dz;
   assign unused_set_dz = set_dz;
`endif

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] in1, in2;
   logic [7:0] quotient, remainder;
   logic       busy, done;
`ifdef DIVZERO_FLAG_EN
   logic       div_zero;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in1       (in1),
      .in2       (in2),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
`ifdef DIVZERO_FLAG_EN
      .done      (done),
      .div_zero  (div_zero)
`else
      .done      (done)
`endif
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      int         lat;
      int         bcnt;
      logic       dz;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drives one start pulse and waits (bounded) for done; lat counts edges
   // from the edge that samples start, inclusive.
   task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int bcnt);
      @(negedge clk);
      in1 = a; in2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1; bcnt = 0;
      while (!done && lat < 600) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, bcnt;
      vecs[0] = '{8'd100, 8'd7, 8'd14,  8'd2,   16,  15,  1'b0};
      vecs[1] = '{8'd5,   8'd9, 8'd0,   8'd5,   2,   1,   1'b0};
      vecs[2] = '{8'd0,   8'd3, 8'd0,   8'd0,   2,   1,   1'b0};
      vecs[3] = '{8'd255, 8'd1, 8'd255, 8'd0,   257, 256, 1'b0};
      vecs[4] = '{8'd200, 8'd0, 8'hFF,  8'd200, 1,   0,   1'b1};
      vecs[5] = '{8'd50,  8'd5, 8'd10,  8'd0,   12,  11,  1'b0};

      rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
      repeat (3) @(negedge clk);
      chk("reset_quotient", quotient, 0);
      chk("reset_remainder", remainder, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
`ifdef DIVZERO_FLAG_EN
      chk("reset_div_zero", div_zero, 0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_div(vecs[i].a, vecs[i].b, lat, bcnt);
         chk($sformatf("v%0d_done", i), done, 1);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].bcnt);
         chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
         chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
`ifdef DIVZERO_FLAG_EN
         chk($sformatf("v%0d_div_zero", i), div_zero, vecs[i].dz);
`endif
      end

      // start pulsed mid-SUB with different operands must be ignored.
      @(negedge clk);
      in1 = 8'd50; in2 = 8'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0; lat = 1;
      repeat (3) begin @(negedge clk); lat++; end
      in1 = 8'd33; in2 = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0; lat++;
      chk("midsub_busy", busy, 1);
      while (!done && lat < 600) begin @(negedge clk); lat++; end
      chk("midsub_latency", lat, 12);
      chk("midsub_quotient", quotient, 10);
      chk("midsub_remainder", remainder, 0);

      // reset during SUB cycle 3 of 90/4.
      @(negedge clk);
      in1 = 8'd90; in2 = 8'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("prerst_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_quotient", quotient, 0);
      chk("rst_mid_remainder", remainder, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
`ifdef DIVZERO_FLAG_EN
      chk("rst_mid_div_zero", div_zero, 0);
`endif
      @(negedge clk);
      chk("idle_hold_busy", busy, 0);
      chk("idle_hold_done", done, 0);
      run_div(8'd9, 8'd4, lat, bcnt);
      chk("post_rst_latency", lat, 4);
      chk("post_rst_quotient", quotient, 2);
      chk("post_rst_remainder", remainder, 1);

      // back-to-back: start held high while in DONE reloads without IDLE.
      run_div(8'd20, 8'd3, lat, bcnt);
      chk("b2b1_quotient", quotient, 6);
      chk("b2b1_remainder", remainder, 2);
      in1 = 8'd21; in2 = 8'd3; start = 1'b1;
      @(negedge clk);
      lat = 1;
      chk("b2b2_busy_first", busy, 1);
      chk("b2b2_done_low", done, 0);
      while (!done && lat < 600) begin @(negedge clk); lat++; end
      chk("b2b2_latency", lat, 9);
      chk("b2b2_quotient", quotient, 7);
      chk("b2b2_remainder", remainder, 0);
      start = 1'b0;
      @(negedge clk);
      chk("b2b2_hold_done", done, 1);
      chk("b2b2_hold_quotient", quotient, 7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
